// File: rtl/music_tone_gen.sv
// Tone-code to square-wave buzzer driver: registers the incoming code, retunes only on
// half-period boundaries and pulses flags on end-of-song and invalid codes.
module music_tone_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned END_CODE    = 22
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] music_tone,
  input  logic       tone_mute,
  output logic       beep,
  output logic       tone_active,
  output logic       song_done,
  output logic       tone_err
);

  typedef enum logic [0:0] {StSilent, StPlay} state_e;

  localparam int unsigned NumNotes = 21;
  localparam int unsigned NoteHz [NumNotes + 1] = '{
    0,
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988,
    1047, 1175, 1319, 1397, 1568, 1760, 1976
  };

  logic [7:0]       r_tone_q;
  logic [7:0]       r_tone_prev_q;
  state_e           r_state_q;
  logic [CNT_W-1:0] r_cnt_q;
  logic [CNT_W-1:0] r_half_q;
  logic             r_beep_q;
  logic             r_done_q;
  logic             r_err_q;

  state_e           w_state_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W-1:0] w_half_d;
  logic             w_beep_d;
  logic [CNT_W-1:0] w_half_tbl [32];
  logic [CNT_W-1:0] w_half_sel;
  logic             w_play_req;
  logic             w_boundary;
  logic             w_tone_chg;

  // Half-period table folded to constants at elaboration; unused slots read as rest.
  for (genvar gi = 0; gi < 32; gi++) begin : g_tbl
    if (gi >= 1 && gi <= NumNotes) begin : g_note
      assign w_half_tbl[gi] = CNT_W'(CLK_FREQ_HZ / (2 * NoteHz[gi]));
    end else begin : g_rest
      assign w_half_tbl[gi] = '0;
    end
  end

  assign w_half_sel = w_half_tbl[r_tone_q[4:0]];
  assign w_play_req = (r_tone_q != 8'd0) && (r_tone_q <= 8'(NumNotes)) &&
                      (r_tone_q < 8'(END_CODE)) && !tone_mute;
  assign w_boundary = (r_cnt_q == r_half_q - CNT_W'(1));
  assign w_tone_chg = (r_tone_q != r_tone_prev_q);

  always_comb begin
    w_state_d = r_state_q;
    w_cnt_d   = r_cnt_q;
    w_half_d  = r_half_q;
    w_beep_d  = r_beep_q;
    unique case (r_state_q)
      StSilent: begin
        w_beep_d = 1'b0;
        w_cnt_d  = '0;
        if (w_play_req) begin
          w_half_d  = w_half_sel;
          w_beep_d  = 1'b1;
          w_state_d = StPlay;
        end
      end
      StPlay: begin
        if (w_boundary) begin
          w_cnt_d = '0;
          // Pitch and stop decisions land only here so no runt pulse is emitted.
          if (w_play_req) begin
            w_beep_d = ~r_beep_q;
            w_half_d = w_half_sel;
          end else begin
            w_beep_d  = 1'b0;
            w_state_d = StSilent;
          end
        end else begin
          w_cnt_d = r_cnt_q + CNT_W'(1);
        end
      end
      default: w_state_d = StSilent;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tone_q      <= '0;
      r_tone_prev_q <= '0;
      r_state_q     <= StSilent;
      r_cnt_q       <= '0;
      r_half_q      <= '0;
      r_beep_q      <= 1'b0;
      r_done_q      <= 1'b0;
      r_err_q       <= 1'b0;
    end else begin
      r_tone_q      <= music_tone;
      r_tone_prev_q <= r_tone_q;
      r_state_q     <= w_state_d;
      r_cnt_q       <= w_cnt_d;
      r_half_q      <= w_half_d;
      r_beep_q      <= w_beep_d;
      r_done_q      <= w_tone_chg && (r_tone_q == 8'(END_CODE));
      r_err_q       <= w_tone_chg && (r_tone_q > 8'(END_CODE));
    end
  end

  assign beep        = r_beep_q;
  assign tone_active = (r_state_q == StPlay);
  assign song_done   = r_done_q;
  assign tone_err    = r_err_q;

endmodule

// File: tb/tb_music_tone_gen.sv
// Scoreboard bench for music_tone_gen: stimulus queues timestamped output events, a
// negedge monitor pops and compares each observed event.
module tb_music_tone_gen;

  localparam int unsigned ClkHz = 1_000_000;
  localparam int KBeep = 0;
  localparam int KAct  = 1;
  localparam int KDone = 2;
  localparam int KErr  = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] music_tone = 8'd0;
  logic       tone_mute = 1'b0;
  logic       beep;
  logic       tone_active;
  logic       song_done;
  logic       tone_err;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rst_req = 0;
  int   rst_seen = 0;
  bit   mon_en = 1'b0;
  bit   fin_req = 1'b0;
  bit   fin_ack = 1'b0;
  int   t;

  music_tone_gen #(
    .CLK_FREQ_HZ(ClkHz),
    .CNT_W      (20),
    .END_CODE   (22)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .music_tone (music_tone),
    .tone_mute  (tone_mute),
    .beep       (beep),
    .tone_active(tone_active),
    .song_done  (song_done),
    .tone_err   (tone_err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Advance to just after the posedge that brings the cycle count to c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic sb_pop(input int kind, input int val);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d cycle=%0d, expected no event",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL sb_event: got kind=%0d val=%0d cycle=%0d, expected kind=%0d val=%0d cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  task automatic chk_zero(input string name, input logic v);
    n_tests++;
    if (v !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected 0", name, v);
    end
  endtask

  // Monitor
  initial begin
    logic p_beep;
    logic p_act;
    exp_t e;
    p_beep = 1'b0;
    p_act  = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rst_req != rst_seen) begin
        rst_seen = rst_req;
        chk_zero("rst_beep", beep);
        chk_zero("rst_tone_active", tone_active);
        chk_zero("rst_song_done", song_done);
        chk_zero("rst_tone_err", tone_err);
      end
      if (mon_en) begin
        if (beep !== p_beep) sb_pop(KBeep, int'(beep));
        if (tone_active !== p_act) sb_pop(KAct, int'(tone_active));
        if (song_done === 1'b1) sb_pop(KDone, 1);
        if (tone_err === 1'b1) sb_pop(KErr, 1);
      end
      p_beep = beep;
      p_act  = tone_active;
      if (fin_req && !fin_ack) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_event: got none, expected kind=%0d val=%0d cycle=%0d",
                   e.kind, e.val, e.cyc);
        end
        fin_ack = 1'b1;
      end
    end
  end

  // Stimulus; half periods at 1 MHz: code6=1136 code13=568 code1=1908 code21=253
  // code8=956 code15=477.
  initial begin
    goto(3);
    rst_req++;
    goto(4);
    mon_en = 1'b1;
    goto(5);
    sys_rst = 1'b0;

    // A4 from silence, then two full phases.
    goto(10);
    t = cyc;
    music_tone = 8'd6;
    push(KBeep, 1, t + 2);
    push(KAct, 1, t + 2);
    push(KBeep, 0, t + 1138);
    push(KBeep, 1, t + 2274);

    // Retune to A5 mid high phase: current high phase keeps full length.
    goto(t + 2374);
    music_tone = 8'd13;
    push(KBeep, 0, t + 3410);
    push(KBeep, 1, t + 3978);
    push(KBeep, 0, t + 4546);

    // Retune to C4, then rest during a low phase.
    goto(t + 4556);
    music_tone = 8'd1;
    push(KBeep, 1, t + 5114);
    push(KBeep, 0, t + 7022);
    goto(t + 7072);
    music_tone = 8'd0;
    push(KAct, 0, t + 8930);

    // End of song, repeated END_CODE, then an invalid code.
    goto(t + 9000);
    t = cyc;
    music_tone = 8'd21;
    push(KBeep, 1, t + 2);
    push(KAct, 1, t + 2);
    goto(t + 20);
    music_tone = 8'd22;
    push(KDone, 1, t + 22);
    push(KBeep, 0, t + 255);
    push(KAct, 0, t + 255);
    goto(t + 100);
    music_tone = 8'd22;
    goto(t + 300);
    music_tone = 8'd30;
    push(KErr, 1, t + 302);

    // Mute during a high phase, then release.
    goto(t + 400);
    t = cyc;
    music_tone = 8'd8;
    push(KBeep, 1, t + 2);
    push(KAct, 1, t + 2);
    goto(t + 100);
    tone_mute = 1'b1;
    push(KBeep, 0, t + 958);
    push(KAct, 0, t + 958);
    goto(t + 1000);
    tone_mute = 1'b0;
    push(KBeep, 1, t + 1001);
    push(KAct, 1, t + 1001);
    push(KBeep, 0, t + 1957);

    // Reset mid high phase of C6, then resume.
    goto(t + 1960);
    music_tone = 8'd15;
    push(KBeep, 1, t + 2913);
    goto(t + 3000);
    sys_rst = 1'b1;
    push(KBeep, 0, t + 3001);
    push(KAct, 0, t + 3001);
    goto(t + 3001);
    rst_req++;
    goto(t + 3010);
    sys_rst = 1'b0;
    push(KBeep, 1, t + 3012);
    push(KAct, 1, t + 3012);
    push(KBeep, 0, t + 3489);

    goto(t + 3600);
    music_tone = 8'd0;
    fin_req = 1'b1;
    for (int i = 0; i < 4 && !fin_ack; i++) @(negedge sys_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
